// File: rtl/puf_response_engine.sv
// PUF response engine: sequences enable/challenge to the PUF slices,
// runs NUM_EVALS evaluations and returns a per-bit majority-voted response.
module puf_response_engine #(
    parameter int WIDTH         = 64,
    parameter int CHAL_W        = 2,
    parameter int NUM_EVALS     = 5,
    parameter int SETTLE_CYCLES = 16,
    parameter int OFF_CYCLES    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CHAL_W-1:0]          challenge,
    output logic                       busy,
    output logic                       puf_en,
    output logic [CHAL_W-1:0]          puf_chal,
    input  logic [WIDTH-1:0]           puf_raw,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [WIDTH-1:0]           response,
    output logic [$clog2(WIDTH+1)-1:0] unstable_cnt
);

    localparam int CNT_W   = $clog2(NUM_EVALS + 1);
    localparam int UC_W    = $clog2(WIDTH + 1);
    localparam int TMR_MAX = (SETTLE_CYCLES > OFF_CYCLES) ? SETTLE_CYCLES : OFF_CYCLES;
    localparam int TMR_W   = ($clog2(TMR_MAX) > 0) ? $clog2(TMR_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_SAMPLE, S_OFF, S_VOTE, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0]    eval_q, eval_d;
    logic [CNT_W-1:0]    ones_q [WIDTH];
    logic [CNT_W-1:0]    ones_d [WIDTH];
    logic [CHAL_W-1:0]   chal_q, chal_d;
    logic                en_q, en_d;
    logic                valid_q, valid_d;
    logic [WIDTH-1:0]    resp_q, resp_d;
    logic [UC_W-1:0]     uc_q, uc_d;
    logic [WIDTH-1:0]    sync1_q, sync2_q;
    logic [WIDTH-1:0]    vote;
    logic [UC_W-1:0]     uc_calc;

    // Two-flop synchroniser for the asynchronous slice outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= puf_raw;
            sync2_q <= sync1_q;
        end
    end

    // Majority vote and count of bits that disagreed across evaluations
    always_comb begin
        vote    = '0;
        uc_calc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            vote[i] = (ones_q[i] > CNT_W'(NUM_EVALS / 2));
            if (ones_q[i] != '0 && ones_q[i] != CNT_W'(NUM_EVALS))
                uc_calc = uc_calc + UC_W'(1);
        end
    end

    // Next-state and next-output logic for the evaluation sequencer
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        eval_d  = eval_q;
        ones_d  = ones_q;
        chal_d  = chal_q;
        en_d    = en_q;
        valid_d = valid_q;
        resp_d  = resp_q;
        uc_d    = uc_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    chal_d  = challenge;
                    eval_d  = '0;
                    tmr_d   = '0;
                    en_d    = 1'b1;
                    state_d = S_SETTLE;
                    for (int i = 0; i < WIDTH; i++) ones_d[i] = '0;
                end
            end
            S_SETTLE: begin
                if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_SAMPLE: begin
                for (int i = 0; i < WIDTH; i++)
                    ones_d[i] = ones_q[i] + CNT_W'(sync2_q[i]);
                eval_d = eval_q + CNT_W'(1);
                en_d   = 1'b0;
                tmr_d  = '0;
                if (eval_q + CNT_W'(1) == CNT_W'(NUM_EVALS))
                    state_d = S_VOTE;
                else
                    state_d = S_OFF;
            end
            S_OFF: begin
                if (tmr_q == TMR_W'(OFF_CYCLES - 1)) begin
                    tmr_d   = '0;
                    en_d    = 1'b1;
                    state_d = S_SETTLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_VOTE: begin
                resp_d  = vote;
                uc_d    = uc_calc;
                valid_d = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (resp_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, counters, accumulators and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            eval_q  <= '0;
            chal_q  <= '0;
            en_q    <= 1'b0;
            valid_q <= 1'b0;
            resp_q  <= '0;
            uc_q    <= '0;
            for (int i = 0; i < WIDTH; i++) ones_q[i] <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            eval_q  <= eval_d;
            chal_q  <= chal_d;
            en_q    <= en_d;
            valid_q <= valid_d;
            resp_q  <= resp_d;
            uc_q    <= uc_d;
            for (int i = 0; i < WIDTH; i++) ones_q[i] <= ones_d[i];
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign puf_en       = en_q;
    assign puf_chal     = chal_q;
    assign resp_valid   = valid_q;
    assign response     = resp_q;
    assign unstable_cnt = uc_q;

endmodule
